ram_dump_tx: RTL and testbench
==============================

# ram_dump_tx

Post-halt data-memory dumper for the 16-bit accumulator CPU system. When the CPU raises its halt flag, the block reads a parametrised window of data-RAM words, splits each into bytes MSB-first, and feeds them one at a time to the UART transmitter using a start/done handshake. It sits in the top level between the data RAM's debug read port, the CPU halt flag and the UART TX. It replaces the single-word result output with a configurable multi-word dump.

## Interface
- DATA_LENGTH, 16: RAM word width in bits.
- ADDR_LENGTH, 11: RAM address width in bits.
- N_WORDS, 8: number of words dumped per halt (1..2^ADDR_LENGTH).
- BASE_ADDR, 0: first dumped address.
- BYTE_W, 8: UART payload width.
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_halt  in  1  CPU halt flag (level).
- o_rd_addr  out  ADDR_LENGTH  RAM debug read address.
- i_rd_data  in  DATA_LENGTH  RAM read data, valid one cycle after o_rd_addr.
- o_tx_start  out  1  one-cycle pulse that launches a UART byte.
- o_tx_data  out  BYTE_W  byte to send; held stable from the start pulse until done.
- i_tx_done  in  1  one-cycle pulse from the UART when the byte has been sent.
- o_busy  out  1  high from dump start until the last byte's done.
- o_dump_done  out  1  high after dump completion until i_halt falls.

## Operation
- NBYTES = ceil(DATA_LENGTH/BYTE_W). Each word is zero-extended to NBYTES*BYTE_W bits and sent most-significant byte first.
- Dump address for word k is (BASE_ADDR + k) mod 2^ADDR_LENGTH, so the address wraps past the top of memory.
- State machine:
  - IDLE: waits for a halt rising edge. The edge is detected against a registered copy of i_halt. If i_halt is already high when reset releases, that counts as an edge on the first cycle after reset.
  - READ: drives o_rd_addr.
  - LATCH: captures i_rd_data into the shift register and sets byte_idx = 0.
  - SEND: sets o_tx_start = 1 for one cycle and drives the current byte.
  - WAIT: waits for i_tx_done. On done:
    - more bytes in this word: go to SEND with the next byte;
    - last byte, more words: go to READ with k+1;
    - last byte of the last word: go to DONE.
  - DONE: holds o_dump_done = 1. When i_halt falls, go to IDLE.
- i_tx_done is ignored in every state except WAIT.
- If i_halt falls mid-dump, the dump still completes. It then passes through DONE for one cycle, where halt is already low, and returns to IDLE.
- A new halt edge during a dump or during DONE is ignored. A new dump requires the halt to go low and then high again.
- Reset mid-operation aborts the dump with no partial-byte completion. All outputs return to their reset values on the next edge.
- Reset values: o_rd_addr = BASE_ADDR, o_tx_start = 0, o_tx_data = 0, o_busy = 0, o_dump_done = 0, state IDLE, counters 0.

## Timing
- Halt edge seen at edge t: o_busy = 1 and o_rd_addr valid at t+1.
- Data latched at t+2; first o_tx_start pulse at t+3.
- After each i_tx_done (sampled at edge d):
  - next byte of the same word: next start pulse at d+1;
  - next word: READ at d+1, LATCH at d+2, start at d+3.
- Last done at edge d: o_busy = 0 and o_dump_done = 1 from d+1.
- o_tx_data changes only in the cycle o_tx_start is asserted.

## Structure
- Shared package holds:
  - the state enum (IDLE, READ, LATCH, SEND, WAIT, DONE);
  - the NBYTES derivation function;
  - the counter-width helper clog2 for the word and byte counters.
- Sub-module word_serializer holds the parallel load, the MSB-first byte shift, and the last-byte flag. The FSM and counters stay in ram_dump_tx.

## Test plan
- Default parameters, RAM[0..7] = 0x1234, 0x5678, … 0xF0F0; halt pulses high:
  - UART receives 16 bytes 0x12, 0x34, 0x56, 0x78, … in order;
  - o_dump_done rises after the 16th done.
- BASE_ADDR = 2046, N_WORDS = 4: o_rd_addr sequence is 2046, 2047, 0, 1.
- DATA_LENGTH = 12, RAM[0] = 0xABC, N_WORDS = 1: bytes sent are 0x0A, 0xBC.
- Reset asserted while in WAIT after 3 bytes:
  - o_busy = 0 and o_tx_start = 0 next cycle;
  - a fresh halt edge restarts the dump at BASE_ADDR.
- Spurious i_tx_done in IDLE and READ, and halt toggled low/high mid-dump:
  - byte count is unchanged at 16;
  - no second dump starts;
  - o_dump_done is a single cycle, because halt is already low.
- i_tx_done delayed by 100 cycles: o_tx_data stays stable for the whole wait and no extra start pulse occurs.

Source files
------------

// File: rtl/ram_dump_tx_pkg.sv
// ram_dump_tx_pkg: shared types and helpers for the post-halt RAM dumper.
// Holds the FSM state enum, the bytes-per-word derivation and a counter width helper.
package ram_dump_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  // Bytes needed to carry one RAM word, rounding up.
  function automatic int nbytes(input int dw, input int bw);
    return (dw + bw - 1) / bw;
  endfunction

  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/ram_dump_tx_word_serializer.sv
// word_serializer: loads one RAM word zero-extended to whole bytes and
// presents it MSB byte first. Ports: clk, reset, load, shift, word in; cur_byte, last out.
module word_serializer
  import ram_dump_tx_pkg::*;
#(
  parameter int DATA_LENGTH = 16,
  parameter int BYTE_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [DATA_LENGTH-1:0] word,
  output logic [BYTE_W-1:0]      cur_byte,
  output logic                   last
);

  localparam int NB = nbytes(DATA_LENGTH, BYTE_W);
  localparam int SW = NB * BYTE_W;
  localparam int IW = clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [SW-1:0] sreg;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= SW'(word);
      idx  <= '0;
    end else if (shift) begin
      sreg <= sreg << BYTE_W;
      idx  <= idx + 1'b1;
    end
  end

  assign cur_byte = sreg[SW-1 -: BYTE_W];
  assign last     = (idx == LAST_IDX);

endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: on a CPU halt rising edge, reads N_WORDS RAM words from BASE_ADDR
// and streams them MSB byte first to a UART (start/done). Ports: clock, reset, halt, RAM read port, UART tx, busy/done status.
module ram_dump_tx
  import ram_dump_tx_pkg::*;
#(
  parameter int DATA_LENGTH = 16,
  parameter int ADDR_LENGTH = 11,
  parameter int N_WORDS     = 8,
  parameter int BASE_ADDR   = 0,
  parameter int BYTE_W      = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_halt,
  output logic [ADDR_LENGTH-1:0] o_rd_addr,
  input  logic [DATA_LENGTH-1:0] i_rd_data,
  output logic                   o_tx_start,
  output logic [BYTE_W-1:0]      o_tx_data,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_dump_done
);

  localparam int WCW = clog2(N_WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(N_WORDS - 1);
  localparam logic [ADDR_LENGTH-1:0] BASE = ADDR_LENGTH'(BASE_ADDR);

  state_t         state, state_n;
  logic           halt_q;
  logic           halt_rise;
  logic [WCW-1:0] word_idx, word_idx_n;
  logic           load, shift, last;

  // halt_q resets low, so a halt already high at reset release reads as an edge.
  assign halt_rise = i_halt & ~halt_q;

  // Address arithmetic is truncated to the RAM width, wrapping past the top.
  assign o_rd_addr = BASE + ADDR_LENGTH'(word_idx);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= S_IDLE;
      halt_q   <= 1'b0;
      word_idx <= '0;
    end else begin
      state    <= state_n;
      halt_q   <= i_halt;
      word_idx <= word_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    word_idx_n  = word_idx;
    load        = 1'b0;
    shift       = 1'b0;
    o_tx_start  = 1'b0;
    o_busy      = 1'b0;
    o_dump_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (halt_rise) begin
          state_n    = S_READ;
          word_idx_n = '0;
        end
      end
      S_READ: begin
        o_busy  = 1'b1;
        state_n = S_LATCH;
      end
      S_LATCH: begin
        o_busy  = 1'b1;
        load    = 1'b1;
        state_n = S_SEND;
      end
      S_SEND: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (i_tx_done) begin
          if (!last) begin
            shift   = 1'b1;
            state_n = S_SEND;
          end else if (word_idx != LAST_WORD) begin
            word_idx_n = word_idx + 1'b1;
            state_n    = S_READ;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        o_dump_done = 1'b1;
        if (!i_halt) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  word_serializer #(
    .DATA_LENGTH(DATA_LENGTH),
    .BYTE_W     (BYTE_W)
  ) u_ser (
    .clk     (i_clock),
    .reset   (i_reset),
    .load    (load),
    .shift   (shift),
    .word    (i_rd_data),
    .cur_byte(o_tx_data),
    .last    (last)
  );

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: randomized self-checking bench for ram_dump_tx.
// Three instances: defaults, wrapped base address, and 12-bit words.
module tb_ram_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        halt, tx_done, tx_start, busy, dump_done;
  logic [10:0] rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;

  logic        halt_w, done_w, start_w, busy_w, ddone_w;
  logic [10:0] addr_w;
  logic [15:0] rdata_w;
  logic [7:0]  txd_w;

  logic        halt_n, done_n, start_n, busy_n, ddone_n;
  logic [10:0] addr_n;
  logic [11:0] rdata_n;
  logic [7:0]  txd_n;

  logic [15:0] mem [2048];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    rdata_w <= mem[addr_w];
    rdata_n <= mem[addr_n][11:0];
  end

  ram_dump_tx dut (
    .i_clock(clk), .i_reset(rst), .i_halt(halt),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .o_busy(busy), .o_dump_done(dump_done)
  );

  ram_dump_tx #(.BASE_ADDR(2046), .N_WORDS(4)) dut_w (
    .i_clock(clk), .i_reset(rst), .i_halt(halt_w),
    .o_rd_addr(addr_w), .i_rd_data(rdata_w),
    .o_tx_start(start_w), .o_tx_data(txd_w),
    .i_tx_done(done_w), .o_busy(busy_w), .o_dump_done(ddone_w)
  );

  ram_dump_tx #(.DATA_LENGTH(12), .N_WORDS(1)) dut_n (
    .i_clock(clk), .i_reset(rst), .i_halt(halt_n),
    .o_rd_addr(addr_n), .i_rd_data(rdata_n),
    .o_tx_start(start_n), .o_tx_data(txd_n),
    .i_tx_done(done_n), .o_busy(busy_n), .o_dump_done(ddone_n)
  );

  // Expected byte stream of the default instance: words 0..7, MSB first.
  function automatic void build_exp();
    logic [15:0] w;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      w = mem[(0 + k) % 2048];
      exp_q.push_back(8'(w >> 8));
      exp_q.push_back(8'(w & 16'h00FF));
    end
  endfunction

  // UART model for the default instance: answers each start after a random
  // number of wait cycles, and watches data hold and start spacing.
  task automatic run_uart(input int dmin, input int dmax, input int nexp,
                          input bit toggle, output int first_cyc);
    int cyc, cd, last_done, gap, exp_gap;
    bit pend;
    logic [7:0] held;
    pend = 1'b0; cd = 0; cyc = 0; last_done = 0;
    first_cyc = -1; held = '0;
    got.delete();
    while (got.size() < nexp || pend) begin
      if (cyc >= 5000) begin
        n_cmp++; n_bad++;
        $display("FAIL uart_timeout bytes=%0d want=%0d", got.size(), nexp);
        return;
      end
      @(negedge clk);
      tx_done = 1'b0;
      if (toggle) begin
        if (cyc == 12) halt = 1'b0;
        if (cyc == 17) halt = 1'b1;
        if (cyc == 23) halt = 1'b0;
      end
      if (pend) begin
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== held) begin
          n_bad++;
          $display("FAIL hold cyc=%0d start=%b data=%h want start=0 data=%h",
                   cyc, tx_start, tx_data, held);
        end
        if (cd == 0) begin
          tx_done = 1'b1; pend = 1'b0; last_done = cyc;
        end else cd--;
      end else if (tx_start === 1'b1) begin
        if (got.size() == 0) first_cyc = cyc;
        else begin
          exp_gap = (got.size() % 2 == 0) ? 3 : 1;
          gap = cyc - last_done;
          n_cmp++;
          if (gap != exp_gap) begin
            n_bad++;
            $display("FAIL start_gap byte=%0d got=%0d want=%0d",
                     got.size(), gap, exp_gap);
          end
        end
        got.push_back(tx_data);
        held = tx_data;
        pend = 1'b1;
        cd = int'($urandom_range(dmax, dmin));
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rd_addr !== 11'd0) begin n_bad++; $display("FAIL rst_addr got=%0d want=0", rd_addr); end
    n_cmp++;
    if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_start got=%b want=0", tx_start); end
    n_cmp++;
    if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got=%h want=00", tx_data); end
    n_cmp++;
    if (busy !== 1'b0 || dump_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_status busy=%b done=%b want 0 0", busy, dump_done);
    end
    n_cmp++;
    if (addr_w !== 11'd2046) begin n_bad++; $display("FAIL rst_addr_w got=%0d want=2046", addr_w); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || busy_w !== 1'b0 || busy_n !== 1'b0) begin
      n_bad++; $display("FAIL idle_busy got=%b%b%b want=000", busy, busy_w, busy_n);
    end
  endtask

  task automatic test_basic();
    logic [15:0] init [8];
    int fc;
    init = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
             16'h0F1E, 16'h2D3C, 16'h4B5A, 16'hF0F0};
    for (int k = 0; k < 8; k++) mem[k] = init[k];
    build_exp();
    @(negedge clk); halt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rd_addr !== 11'd0) begin
      n_bad++; $display("FAIL basic_start busy=%b addr=%0d want 1 0", busy, rd_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_start !== 1'b0) begin n_bad++; $display("FAIL basic_early got=%b want=0", tx_start); end
    run_uart(0, 3, 16, 1'b0, fc);
    n_cmp++;
    if (fc != 0) begin n_bad++; $display("FAIL basic_first got=%0d want=0", fc); end
    n_cmp++;
    if (got.size() != 16) begin n_bad++; $display("FAIL basic_count got=%0d want=16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    @(negedge clk); tx_done = 1'b0;
    n_cmp++;
    if (dump_done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_end done=%b busy=%b want 1 0", dump_done, busy);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dump_done !== 1'b1) begin n_bad++; $display("FAIL basic_hold got=%b want=1", dump_done); end
    halt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dump_done !== 1'b0) begin n_bad++; $display("FAIL basic_clear got=%b want=0", dump_done); end
  endtask

  task automatic test_random();
    int fc;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
      build_exp();
      @(negedge clk); halt = 1'b1;
      run_uart(0, 5, 16, 1'b0, fc);
      n_cmp++;
      if (fc != 2) begin n_bad++; $display("FAIL rand_first got=%0d want=2", fc); end
      for (int i = 0; i < 16 && i < got.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rand_byte%0d got=%h want=%h", i, got[i], exp_q[i]);
        end
      end
      @(negedge clk); tx_done = 1'b0;
      n_cmp++;
      if (dump_done !== 1'b1) begin n_bad++; $display("FAIL rand_done got=%b want=1", dump_done); end
      halt = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int fc;
    for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
    build_exp();
    @(negedge clk); halt = 1'b1;
    run_uart(0, 2, 3, 1'b0, fc);
    @(negedge clk); tx_done = 1'b0;
    n_cmp++;
    if (tx_start !== 1'b1) begin n_bad++; $display("FAIL mid_4th got=%b want=1", tx_start); end
    @(negedge clk);
    rst = 1'b1; halt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || dump_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset busy=%b start=%b data=%h done=%b want 0 0 00 0",
               busy, tx_start, tx_data, dump_done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rd_addr !== 11'd0) begin
      n_bad++; $display("FAIL mid_restart busy=%b addr=%0d want 1 0", busy, rd_addr);
    end
    @(negedge clk);
    run_uart(0, 2, 16, 1'b0, fc);
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL mid_byte%0d got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    @(negedge clk); tx_done = 1'b0;
    halt = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious();
    int fc;
    bit quiet;
    for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
    build_exp();
    repeat (3) begin @(negedge clk); tx_done = 1'b1; end
    @(negedge clk); tx_done = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_bad++; $display("FAIL spur_idle busy=%b start=%b want 0 0", busy, tx_start);
    end
    halt = 1'b1;
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b1;
    run_uart(1, 1, 16, 1'b1, fc);
    n_cmp++;
    if (fc != 0) begin n_bad++; $display("FAIL spur_first got=%0d want=0", fc); end
    n_cmp++;
    if (got.size() != 16) begin n_bad++; $display("FAIL spur_count got=%0d want=16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL spur_byte%0d got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    @(negedge clk); tx_done = 1'b0;
    n_cmp++;
    if (dump_done !== 1'b1) begin n_bad++; $display("FAIL spur_done got=%b want=1", dump_done); end
    @(negedge clk);
    n_cmp++;
    if (dump_done !== 1'b0) begin n_bad++; $display("FAIL spur_single got=%b want=0", dump_done); end
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL spur_redump got=active want=idle"); end
  endtask

  task automatic test_long_wait();
    int fc;
    for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
    build_exp();
    @(negedge clk); halt = 1'b1;
    run_uart(100, 100, 16, 1'b0, fc);
    n_cmp++;
    if (got.size() != 16) begin n_bad++; $display("FAIL long_count got=%0d want=16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL long_byte%0d got=%h want=%h", i, got[i], exp_q[i]);
      end
    end
    @(negedge clk); tx_done = 1'b0;
    halt = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [10:0] ea[$], ga[$];
    logic [7:0]  eb[$], gb[$];
    logic [10:0] a;
    bit pend;
    int cyc;
    for (int k = 0; k < 4; k++) begin
      a = 11'((2046 + k) % 2048);
      mem[a] = 16'($urandom);
      ea.push_back(a); ea.push_back(a);
      eb.push_back(mem[a][15:8]); eb.push_back(mem[a][7:0]);
    end
    pend = 1'b0; cyc = 0;
    @(negedge clk); halt_w = 1'b1;
    while (ddone_w !== 1'b1 && cyc < 500) begin
      @(negedge clk); done_w = 1'b0; cyc++;
      if (pend) begin done_w = 1'b1; pend = 1'b0; end
      else if (start_w === 1'b1) begin
        ga.push_back(addr_w); gb.push_back(txd_w); pend = 1'b1;
      end
    end
    n_cmp++;
    if (cyc >= 500 || ga.size() != 8) begin
      n_bad++; $display("FAIL wrap_count got=%0d want=8 cyc=%0d", ga.size(), cyc);
    end
    for (int i = 0; i < 8 && i < ga.size(); i++) begin
      n_cmp++;
      if (ga[i] !== ea[i] || gb[i] !== eb[i]) begin
        n_bad++;
        $display("FAIL wrap_%0d got addr=%0d byte=%h want addr=%0d byte=%h",
                 i, ga[i], gb[i], ea[i], eb[i]);
      end
    end
    halt_w = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_narrow();
    logic [11:0] w;
    logic [15:0] ext;
    logic [7:0]  gb[$];
    bit pend;
    int cyc;
    for (int r = 0; r < 2; r++) begin
      w = (r == 0) ? 12'hABC : 12'($urandom);
      mem[0] = {4'h0, w};
      ext = {4'h0, w};
      gb.delete(); pend = 1'b0; cyc = 0;
      @(negedge clk); halt_n = 1'b1;
      while (ddone_n !== 1'b1 && cyc < 200) begin
        @(negedge clk); done_n = 1'b0; cyc++;
        if (pend) begin done_n = 1'b1; pend = 1'b0; end
        else if (start_n === 1'b1) begin gb.push_back(txd_n); pend = 1'b1; end
      end
      n_cmp++;
      if (gb.size() != 2) begin
        n_bad++; $display("FAIL narrow_count got=%0d want=2", gb.size());
      end else begin
        n_cmp++;
        if (gb[0] !== ext[15:8] || gb[1] !== ext[7:0]) begin
          n_bad++;
          $display("FAIL narrow_bytes got=%h %h want=%h %h", gb[0], gb[1], ext[15:8], ext[7:0]);
        end
      end
      halt_n = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    rst = 1'b1;
    halt = 1'b0; tx_done = 1'b0;
    halt_w = 1'b0; done_w = 1'b0;
    halt_n = 1'b0; done_n = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_reset_mid();
    test_spurious();
    test_long_wait();
    test_wrap();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
